lsu_dbus: RTL and testbench
===========================

Name: lsu_dbus

Overview:
- Load/store unit that sits directly downstream of the single-cycle RISC-V core's memory port.
- Consumes the core's memop, address, store data and read/write strobes.
- Drives a word-aligned request/grant/response data bus, stalls the core until the access completes, and returns load data that is aligned and sign- or zero-extended.
- Flags misaligned accesses, illegal memop codes and bus timeouts instead of issuing or hanging a transfer.

Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted with err; counter width is 8 bits, so the legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cpu_ren  in  1  core requests a load this cycle; held until done.
- cpu_wen  in  1  core requests a store this cycle; held until done.
- cpu_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; all other codes are illegal.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- stall  out  1  core must hold its PC and inputs.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, illegal or timeout.
- load_data  out  32  extended load result; valid with done.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {cpu_addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte-lane enables; 0000 on reads.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  response/ack valid.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0: done, err, load_data, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb.
  - A reset mid-access drops bus_req immediately; a later bus_rvalid is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Stays in IDLE while cpu_ren=cpu_wen=0.
  - On a request: latch memop, addr[1:0], bus fields and the direction; go to REQ. If both ren and wen are 1, it is treated as a store.
  - On an error request (see below): go to DONE with err_q=1 and issue no bus access.
- Error requests:
  - Illegal memop.
  - Half access (h, hu, sh) with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Store with memop 100 or 101.
- REQ:
  - bus_req=1, and all bus fields stay stable until bus_gnt.
  - bus_gnt=1 → WAIT, and bus_req deasserts on the next cycle.
- WAIT:
  - bus_rvalid=1 → capture and extend the read data (stores just take the ack), then go to DONE.
  - bus_rvalid is guaranteed at least one cycle after gnt; rvalid outside WAIT is ignored.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT: go to DONE with err=1, load_data=0, and drop bus_req.
- DONE:
  - done=1 and err as latched, for exactly one cycle; then go to IDLE.
  - The core advances this cycle, so IDLE accepts a new request on the following cycle.
- stall is combinational: (cpu_ren|cpu_wen) & (state≠DONE).
  - An idle core is never stalled.
  - An error request stalls for exactly one cycle (the IDLE cycle).
- Latency:
  - The minimum access takes 4 cycles from the request: IDLE, REQ with gnt, WAIT with rvalid, DONE.
  - Errors take 2 cycles.
- Store lanes, with a = addr[1:0]:
  - sb: wdata={4{wdata[7:0]}}, wstrb=0001<<a.
  - sh: wdata={2{wdata[15:0]}}, wstrb=0011<<{a[1],0}.
  - sw: wdata unchanged, wstrb=1111.
- Load:
  - Shift the word right: sh = bus_rdata>>(8*a).
  - b → sign-extend sh[7:0]; bu → zero-extend sh[7:0]; h → sign-extend sh[15:0]; hu → zero-extend sh[15:0]; w → bus_rdata.
- load_data:
  - Holds its value from DONE until the next capture.
  - Is 0 after an error or a store.

Test Plan:
1. lw at 0x80000004; gnt in REQ cycle 1; rvalid 2 cycles later with rdata=0xDEADBEEF → bus_addr=0x80000004, wstrb=0000, stall high 4 cycles, done with load_data=0xDEADBEEF, err=0.
2. lb at 0x103, rdata=0x80FF1234 → load_data=0xFFFFFF80; the same access as lbu → 0x00000080; lhu at 0x102 → 0x000080FF.
3. sb at 0x201 with wdata=0x000000A5 → bus_we=1, bus_addr=0x200, wdata=0xA5A5A5A5, wstrb=0010; sh at 0x202 → wstrb=1100; done after rvalid ack.
4. lw at 0x302 and sh at 0x301 → bus_req never asserted, stall 1 cycle, done=1 with err=1, load_data=0; memop=011 gives the same result.
5. bus_gnt held low, TIMEOUT=8 → bus_req high 8 cycles then low; done=1, err=1; a late rvalid is ignored and the state is IDLE.
6. Reset asserted in WAIT → all outputs 0 asynchronously; after release, a back-to-back lw then sw each complete with correct done pulses and no lost request.

Source files
------------

// File: rtl/lsu_dbus.sv
// lsu_dbus: load/store unit between a single-cycle RISC-V core and a
// word-aligned req/gnt/rvalid data bus. It stalls the core for the whole
// access, aligns and extends load data, replicates store data across byte
// lanes, and turns misaligned/illegal requests and bus timeouts into a
// done+err completion instead of a bus transfer.
//
// Bus handshake: bus_req is held with all bus_* fields stable from the REQ
// entry until the cycle bus_gnt is sampled high; bus_req drops the next
// cycle. The response (read data or store ack) is the first cycle with
// bus_rvalid=1 while in WAIT; bus_rvalid in any other state is ignored.
module lsu_dbus #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [2:0]  cpu_memop,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Last counter value before the abort; the counter counts REQ+WAIT cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  memop_q;
   logic [1:0]  lo_q;

   logic        legal;
   logic        bad_req;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [15:0] lane;
   logic [31:0] ld_ext;

   // Classify the incoming request: legal code, alignment, store-only rules.
   always_comb begin
      legal = 1'b0;
      case (cpu_memop)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      bad_req = !legal
              | ((cpu_memop[1:0] == 2'b01) & cpu_addr[0])
              | ((cpu_memop == 3'b010) & (cpu_addr[1:0] != 2'b00))
              | (cpu_wen & cpu_memop[2]);
   end

   // Replicate store data onto every lane and enable only the addressed bytes.
   always_comb begin
      st_wdata = cpu_wdata;
      st_wstrb = 4'b1111;
      case (cpu_memop[1:0])
         2'b00: begin
            st_wdata = {4{cpu_wdata[7:0]}};
            st_wstrb = 4'b0001 << cpu_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{cpu_wdata[15:0]}};
            st_wstrb = 4'b0011 << {cpu_addr[1], 1'b0};
         end
         default: begin
            st_wdata = cpu_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
      if (!cpu_wen) st_wstrb = 4'b0000;
   end

   // Right-align the addressed bytes of the read word and extend per memop.
   always_comb begin
      lane   = 16'(bus_rdata >> {lo_q, 3'b000});
      ld_ext = 32'd0;
      case (memop_q)
         3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
         3'b100:  ld_ext = {24'd0, lane[7:0]};
         3'b001:  ld_ext = {{16{lane[15]}}, lane};
         3'b101:  ld_ext = {16'd0, lane};
         3'b010:  ld_ext = bus_rdata;
         default: ld_ext = 32'd0;
      endcase
   end

   // Access FSM with registered completion and bus outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         memop_q   <= 3'd0;
         lo_q      <= 2'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         load_data <= 32'd0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_wstrb <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_ren | cpu_wen) begin
                  if (bad_req) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     err       <= 1'b1;
                     load_data <= 32'd0;
                  end else begin
                     state     <= S_REQ;
                     cnt       <= 8'd0;
                     memop_q   <= cpu_memop;
                     lo_q      <= cpu_addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= cpu_wen;
                     bus_addr  <= {cpu_addr[31:2], 2'b00};
                     bus_wdata <= st_wdata;
                     bus_wstrb <= st_wstrb;
                  end
               end
            end
            S_REQ: begin
               // A grant on the last allowed cycle still wins over the abort.
               if (bus_gnt) begin
                  state   <= S_WAIT;
                  bus_req <= 1'b0;
                  cnt     <= cnt + 8'd1;
               end else if (cnt >= CNT_LAST) begin
                  state     <= S_DONE;
                  bus_req   <= 1'b0;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  load_data <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WAIT: begin
               if (bus_rvalid) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  err       <= 1'b0;
                  load_data <= bus_we ? 32'd0 : ld_ext;
               end else if (cnt >= CNT_LAST) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  load_data <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

   // The core advances during DONE; any other cycle with a request holds it.
   assign stall     = (cpu_ren | cpu_wen) & (state != S_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_lsu_dbus.sv
// Directed bench for lsu_dbus: one task per scenario with inline checks.
module tb_lsu_dbus;

   logic        clk;
   logic        rst;
   logic        cpu_ren;
   logic        cpu_wen;
   logic [2:0]  cpu_memop;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] load_data;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // Observations collected by the access driver.
   int          o_stall;
   int          o_req;
   logic        o_done;
   logic        o_err;
   logic        o_to;
   logic        o_we;
   logic        o_done_after;
   logic [31:0] o_ld;
   logic [31:0] o_addr;
   logic [31:0] o_wdata;
   logic [3:0]  o_wstrb;
   logic [1:0]  o_state_after;

   lsu_dbus #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_ren    (cpu_ren),
      .cpu_wen    (cpu_wen),
      .cpu_memop  (cpu_memop),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .stall      (stall),
      .done       (done),
      .err        (err),
      .load_data  (load_data),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wstrb  (bus_wstrb),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Drives one core access and a bus responder. Called at #1 after a
   // posedge with the DUT idle; returns at #1 after the posedge that
   // follows the DONE cycle, with the core inputs already released.
   // gnt_wait: REQ cycles before gnt (negative = never). rv_wait: cycles
   // after the gnt cycle until rvalid.
   task automatic access(input logic ren, input logic wen, input logic [2:0] memop,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_wait, input int rv_wait);
      int  req_seen;
      int  post;
      bit  granted;
      req_seen = 0; post = 0; granted = 0;
      o_stall = 0; o_req = 0; o_done = 0; o_err = 0; o_to = 0; o_we = 0;
      o_ld = '0; o_addr = '0; o_wdata = '0; o_wstrb = '0;
      o_done_after = 1'b1; o_state_after = 2'd3;
      cpu_ren = ren; cpu_wen = wen; cpu_memop = memop; cpu_addr = addr; cpu_wdata = wdata;
      for (int c = 0; c < 300; c++) begin
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
         if (bus_req && !granted) begin
            if (req_seen == 0) begin
               o_addr = bus_addr; o_we = bus_we; o_wdata = bus_wdata; o_wstrb = bus_wstrb;
            end
            if (gnt_wait >= 0 && req_seen == gnt_wait) begin
               bus_gnt = 1'b1;
               granted = 1;
            end
            req_seen++;
         end else if (granted) begin
            post++;
            if (post == rv_wait) begin
               bus_rvalid = 1'b1;
               bus_rdata  = rdata;
            end
         end
         @(negedge clk);
         if (stall)   o_stall++;
         if (bus_req) o_req++;
         if (done) begin
            o_done = 1'b1; o_err = err; o_ld = load_data;
            break;
         end
         @(posedge clk); #1;
      end
      if (!o_done) o_to = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      o_done_after  = done;
      o_state_after = dbg_state;
      cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_memop = 3'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_memop = 3'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
      checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rst_load_data got %h want 0", load_data); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b want 0", bus_req); end
      checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we got %b want 0", bus_we); end
      checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rst_bus_addr got %h want 0", bus_addr); end
      checks++; if (bus_wdata !== 32'd0) begin errors++; $display("FAIL rst_bus_wdata got %h want 0", bus_wdata); end
      checks++; if (bus_wstrb !== 4'd0) begin errors++; $display("FAIL rst_bus_wstrb got %b want 0", bus_wstrb); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", dbg_state); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lw;
      access(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 2);
      checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL lw_timeout no done pulse seen"); end
      checks++; if (o_addr !== 32'h8000_0004) begin errors++; $display("FAIL lw_bus_addr got %h want 80000004", o_addr); end
      checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lw_bus_we got %b want 0", o_we); end
      checks++; if (o_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_wstrb got %b want 0000", o_wstrb); end
      checks++; if (o_req !== 1) begin errors++; $display("FAIL lw_req_cycles got %0d want 1", o_req); end
      checks++; if (o_stall !== 4) begin errors++; $display("FAIL lw_stall_cycles got %0d want 4", o_stall); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", o_err); end
      checks++; if (o_ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_load_data got %h want deadbeef", o_ld); end
      checks++; if (o_done_after !== 1'b0) begin errors++; $display("FAIL lw_done_width got %b want 0 after one cycle", o_done_after); end
      checks++; if (o_state_after !== 2'd0) begin errors++; $display("FAIL lw_state_after got %0d want 0", o_state_after); end
      checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_load_hold got %h want deadbeef", load_data); end
   endtask

   task automatic test_load_extend;
      logic [2:0]  op_t  [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
      logic [31:0] ad_t  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
      logic [31:0] exp_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0012};
      for (int i = 0; i < 5; i++) begin
         access(1'b1, 1'b0, op_t[i], ad_t[i], 32'd0, 32'h80FF_1234, 0, 1);
         checks++; if (o_done !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL ld%0d_done got done=%b err=%b want 1 0", i, o_done, o_err); end
         checks++; if (o_ld !== exp_t[i]) begin errors++; $display("FAIL ld%0d_load_data got %h want %h", i, o_ld, exp_t[i]); end
         checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL ld%0d_bus_addr got %h want 00000100", i, o_addr); end
      end
   endtask

   task automatic test_store_lanes;
      logic [2:0]  op_t [5] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
      logic [31:0] ad_t [5] = '{32'h201, 32'h202, 32'h204, 32'h203, 32'h200};
      logic [31:0] wd_t [5] = '{32'h0000_00A5, 32'h0000_BEEF, 32'h1234_5678, 32'h0000_0077, 32'h0000_1234};
      logic [31:0] ba_t [5] = '{32'h200, 32'h200, 32'h204, 32'h200, 32'h200};
      logic [31:0] bw_t [5] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1234_5678, 32'h7777_7777, 32'h1234_1234};
      logic [3:0]  bs_t [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
      for (int i = 0; i < 5; i++) begin
         access(1'b0, 1'b1, op_t[i], ad_t[i], wd_t[i], 32'hFFFF_FFFF, 0, 1);
         checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL st%0d_bus_we got %b want 1", i, o_we); end
         checks++; if (o_addr !== ba_t[i]) begin errors++; $display("FAIL st%0d_bus_addr got %h want %h", i, o_addr, ba_t[i]); end
         checks++; if (o_wdata !== bw_t[i]) begin errors++; $display("FAIL st%0d_bus_wdata got %h want %h", i, o_wdata, bw_t[i]); end
         checks++; if (o_wstrb !== bs_t[i]) begin errors++; $display("FAIL st%0d_wstrb got %b want %b", i, o_wstrb, bs_t[i]); end
         checks++; if (o_done !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL st%0d_done got done=%b err=%b want 1 0", i, o_done, o_err); end
         checks++; if (o_ld !== 32'd0) begin errors++; $display("FAIL st%0d_load_data got %h want 0", i, o_ld); end
      end
      // both strobes high is a store
      access(1'b1, 1'b1, 3'b000, 32'h301, 32'h0000_003C, 32'd0, 0, 1);
      checks++; if (o_we !== 1'b1 || o_wstrb !== 4'b0010) begin errors++; $display("FAIL st_both_dir got we=%b wstrb=%b want 1 0010", o_we, o_wstrb); end
   endtask

   task automatic test_errors;
      logic        wen_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  op_t  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
      logic [31:0] ad_t  [5] = '{32'h302, 32'h301, 32'h300, 32'h300, 32'h305};
      // leave a nonzero result so the clear on error is visible
      access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h1111_2222, 0, 1);
      checks++; if (o_ld !== 32'h1111_2222) begin errors++; $display("FAIL err_pre_load got %h want 11112222", o_ld); end
      for (int i = 0; i < 5; i++) begin
         access(!wen_t[i], wen_t[i], op_t[i], ad_t[i], 32'hFFFF_FFFF, 32'd0, 0, 1);
         checks++; if (o_req !== 0) begin errors++; $display("FAIL err%0d_bus_req got %0d cycles want 0", i, o_req); end
         checks++; if (o_stall !== 1) begin errors++; $display("FAIL err%0d_stall got %0d cycles want 1", i, o_stall); end
         checks++; if (o_done !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL err%0d_flag got done=%b err=%b want 1 1", i, o_done, o_err); end
         checks++; if (o_ld !== 32'd0) begin errors++; $display("FAIL err%0d_load_data got %h want 0", i, o_ld); end
         checks++; if (o_state_after !== 2'd0) begin errors++; $display("FAIL err%0d_state got %0d want 0", i, o_state_after); end
      end
   endtask

   task automatic test_timeout;
      access(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 32'd0, -1, 1);
      checks++; if (o_req !== 8) begin errors++; $display("FAIL to_req_cycles got %0d want 8", o_req); end
      checks++; if (o_stall !== 9) begin errors++; $display("FAIL to_stall_cycles got %0d want 9", o_stall); end
      checks++; if (o_done !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL to_flag got done=%b err=%b want 1 1", o_done, o_err); end
      checks++; if (o_ld !== 32'd0) begin errors++; $display("FAIL to_load_data got %h want 0", o_ld); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_req_after got %b want 0", bus_req); end
      // late response must be ignored
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_late_done got %b want 0", done); end
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_rdata = 32'd0;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL to_late_state got %0d want 0", dbg_state); end
      checks++; if (done !== 1'b0 || load_data !== 32'd0) begin errors++; $display("FAIL to_late_out got done=%b ld=%h want 0 0", done, load_data); end
   endtask

   task automatic test_back_to_back;
      access(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'hCAFE_F00D, 0, 1);
      checks++; if (o_ld !== 32'hCAFE_F00D) begin errors++; $display("FAIL rw_pre_load got %h want cafef00d", o_ld); end
      // start a load and reset while it waits for the response
      cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_memop = 3'b010; cpu_addr = 32'h8000_0010; cpu_wdata = 32'h55AA_55AA;
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rw_in_wait got %0d want 2", dbg_state); end
      #2 rst = 1'b0;
      #1;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rw_state got %0d want 0", dbg_state); end
      checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rw_load_data got %h want 0", load_data); end
      checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rw_bus_addr got %h want 0", bus_addr); end
      checks++; if (bus_wdata !== 32'd0) begin errors++; $display("FAIL rw_bus_wdata got %h want 0", bus_wdata); end
      checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_wstrb !== 4'd0) begin errors++; $display("FAIL rw_bus_ctl got req=%b we=%b wstrb=%b want 0 0 0", bus_req, bus_we, bus_wstrb); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rw_done_err got %b %b want 0 0", done, err); end
      bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      cpu_ren = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || load_data !== 32'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rw_after_release got done=%b ld=%h st=%0d want 0 0 0", done, load_data, dbg_state); end
      bus_rvalid = 1'b0; bus_rdata = 32'd0;
      // back-to-back load then store with no idle gap between them
      access(1'b1, 1'b0, 3'b010, 32'h700, 32'd0, 32'h0BAD_C0DE, 0, 1);
      checks++; if (o_done !== 1'b1 || o_ld !== 32'h0BAD_C0DE) begin errors++; $display("FAIL b2b_lw got done=%b ld=%h want 1 0badc0de", o_done, o_ld); end
      checks++; if (o_stall !== 3) begin errors++; $display("FAIL b2b_lw_stall got %0d want 3", o_stall); end
      access(1'b0, 1'b1, 3'b010, 32'h704, 32'h1357_2468, 32'd0, 1, 1);
      checks++; if (o_done !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL b2b_sw_done got done=%b err=%b want 1 0", o_done, o_err); end
      checks++; if (o_addr !== 32'h704 || o_wdata !== 32'h1357_2468 || o_wstrb !== 4'b1111) begin errors++; $display("FAIL b2b_sw_bus got %h %h %b want 00000704 13572468 1111", o_addr, o_wdata, o_wstrb); end
      checks++; if (o_req !== 2) begin errors++; $display("FAIL b2b_sw_req got %0d want 2", o_req); end
      checks++; if (o_ld !== 32'd0 || o_done_after !== 1'b0) begin errors++; $display("FAIL b2b_sw_tail got ld=%h done_after=%b want 0 0", o_ld, o_done_after); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_extend();
      test_store_lanes();
      test_errors();
      test_timeout();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
